// File: rtl/otter_fetch_stage.sv
// Instruction-fetch stage for the pipelined OTTER.
// Drives the PC and instruction memory, and fills the IF/ID register through a 1-entry skid buffer.
module otter_fetch_stage #(
    parameter int          ADDR_W = 14,
    parameter logic [31:0] NOP    = 32'h00000013
) (
    input  logic              IF_CLK,
    input  logic              IF_RST,
    input  logic [31:0]       IF_PC,
    output logic              IF_PC_LD,
    output logic [31:0]       IF_NEXT_PC,
    input  logic              IF_STALL,
    input  logic              IF_FLUSH,
    input  logic [31:0]       IF_TARGET,
    output logic              IF_MEM_RDEN,
    output logic [ADDR_W-1:0] IF_MEM_ADDR,
    input  logic [31:0]       IF_MEM_DOUT,
    output logic [31:0]       IF_ID_PC,
    output logic [31:0]       IF_ID_PC4,
    output logic [31:0]       IF_ID_INSTR,
    output logic              IF_ID_VALID
);

    logic        issue;
    logic        req_valid;
    logic [31:0] req_pc;
    logic        skid_valid;
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;

    always_comb begin
        issue       = !IF_RST && !IF_FLUSH && !IF_STALL;
        IF_MEM_RDEN = issue;
        IF_MEM_ADDR = IF_PC[ADDR_W+1:2];
        IF_PC_LD    = !IF_RST && (issue || IF_FLUSH);
        IF_NEXT_PC  = IF_FLUSH ? IF_TARGET : IF_PC + 32'd4;
    end

    // The skid only ever fills during a stall, and a stall blocks issue,
    // so skid drain and a live response never land on the same edge.
    always_ff @(posedge IF_CLK) begin
        if (IF_RST) begin
            req_valid   <= 1'b0;
            skid_valid  <= 1'b0;
            IF_ID_VALID <= 1'b0;
            IF_ID_PC    <= 32'd0;
            IF_ID_PC4   <= 32'd4;
            IF_ID_INSTR <= NOP;
        end else begin
            req_valid <= issue;
            req_pc    <= IF_PC;
            if (IF_FLUSH) begin
                IF_ID_VALID <= 1'b0;
                IF_ID_INSTR <= NOP;
                skid_valid  <= 1'b0;
            end else if (!IF_STALL) begin
                if (skid_valid) begin
                    IF_ID_VALID <= 1'b1;
                    IF_ID_PC    <= skid_pc;
                    IF_ID_PC4   <= skid_pc + 32'd4;
                    IF_ID_INSTR <= skid_instr;
                    skid_valid  <= 1'b0;
                end else begin
                    IF_ID_VALID <= req_valid;
                    IF_ID_PC    <= req_pc;
                    IF_ID_PC4   <= req_pc + 32'd4;
                    IF_ID_INSTR <= req_valid ? IF_MEM_DOUT : NOP;
                end
            end else if (req_valid) begin
                skid_valid <= 1'b1;
                skid_pc    <= req_pc;
                skid_instr <= IF_MEM_DOUT;
            end
        end
    end

endmodule
